// File: rtl/pm_loader.sv
// pm_loader: receives a framed program image over a valid/ready byte stream, writes it to program
// memory and holds the micro in reset while loading. Define PM_START_ADDR_EN for the ADDR frame byte.
module pm_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter bit          HOLD_AT_RESET  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] pm_wr_addr,
    output logic [7:0] pm_wr_data,
    output logic       pm_wren,
    output logic       cpu_hold,
    output logic       busy,
    output logic       load_ok,
    output logic       load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
`ifdef PM_START_ADDR_EN
        S_ADDR,
`endif
        S_DATA,
        S_CSUM,
        S_RELEASE,
        S_ERROR
    } state_t;

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state, state_n;
    logic [7:0]  len_q, len_n;
    logic [7:0]  count, count_n;
    logic [7:0]  base, base_n;
    logic [7:0]  csum, csum_n;
    logic [15:0] timer, timer_n;
    logic [7:0]  addr_n, data_n;
    logic        wren_n, hold_n, ok_n;
    logic        xfer, in_frame;
    logic [7:0]  sum_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            count      <= '0;
            base       <= '0;
            csum       <= '0;
            timer      <= '0;
            pm_wr_addr <= '0;
            pm_wr_data <= '0;
            pm_wren    <= 1'b0;
            cpu_hold   <= HOLD_AT_RESET;
            load_ok    <= 1'b0;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            count      <= count_n;
            base       <= base_n;
            csum       <= csum_n;
            timer      <= timer_n;
            pm_wr_addr <= addr_n;
            pm_wr_data <= data_n;
            pm_wren    <= wren_n;
            cpu_hold   <= hold_n;
            load_ok    <= ok_n;
        end
    end

    always_comb begin
        in_ready = (state != S_RELEASE) && (state != S_ERROR);
        busy     = (state != S_IDLE);
        load_err = (state == S_ERROR);
        xfer     = in_valid && in_ready;
        sum_in   = csum + in_data;

        state_n  = state;
        len_n    = len_q;
        count_n  = count;
        base_n   = base;
        csum_n   = csum;
        timer_n  = timer;
        addr_n   = pm_wr_addr;
        data_n   = pm_wr_data;
        wren_n   = 1'b0;
        hold_n   = cpu_hold;
        ok_n     = 1'b0;
        in_frame = 1'b0;

        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (xfer && in_data == SYNC_BYTE) begin
                    state_n = S_LEN;
                    hold_n  = 1'b1;
                    csum_n  = '0;
                end
            end
            S_LEN: begin
                in_frame = 1'b1;
                if (xfer) begin
                    len_n   = in_data;
                    csum_n  = sum_in;
                    count_n = '0;
                    base_n  = '0;
`ifdef PM_START_ADDR_EN
                    state_n = S_ADDR;
`else
                    state_n = S_DATA;
`endif
                end
            end
`ifdef PM_START_ADDR_EN
            S_ADDR: begin
                in_frame = 1'b1;
                if (xfer) begin
                    base_n  = in_data;
                    csum_n  = sum_in;
                    state_n = S_DATA;
                end
            end
`endif
            S_DATA: begin
                in_frame = 1'b1;
                if (xfer) begin
                    wren_n  = 1'b1;
                    data_n  = in_data;
                    addr_n  = base + count;
                    csum_n  = sum_in;
                    count_n = count + 8'd1;
                    // LEN=0 ends after index 8'hFF, i.e. 256 bytes
                    if (count == len_q - 8'd1)
                        state_n = S_CSUM;
                end
            end
            S_CSUM: begin
                in_frame = 1'b1;
                if (xfer) begin
                    csum_n  = sum_in;
                    state_n = (sum_in == 8'h00) ? S_RELEASE : S_ERROR;
                end
            end
            S_RELEASE: begin
                // timer doubles as the hold counter; it enters here cleared by the CSUM transfer
                if (timer == HOLD_LAST) begin
                    state_n = S_IDLE;
                    hold_n  = 1'b0;
                    ok_n    = 1'b1;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            S_ERROR: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
            default: state_n = S_IDLE;
        endcase

        if (in_frame) begin
            if (xfer) begin
                timer_n = '0;
            end else if (timer == TO_LAST) begin
                state_n = S_ERROR;
                timer_n = '0;
            end else begin
                timer_n = timer + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader: write scoreboard plus per-scenario checks of handshake and pulses.
module tb_pm_loader;

    localparam int unsigned TO   = 40;
    localparam int unsigned HOLD = 3;
    localparam logic [7:0]  SYNC = 8'hA5;
`ifdef PM_START_ADDR_EN
    localparam bit ADDR_EN = 1'b1;
`else
    localparam bit ADDR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pm_wr_addr;
    logic [7:0] pm_wr_data;
    logic       pm_wren;
    logic       cpu_hold;
    logic       busy;
    logic       load_ok;
    logic       load_err;

    int          errors = 0;
    int          checks = 0;
    int          ok_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic [7:0]  dbuf[256];

    pm_loader #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TO),
        .HOLD_CYCLES(HOLD),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pm_wr_addr(pm_wr_addr),
        .pm_wr_data(pm_wr_data),
        .pm_wren(pm_wren),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .load_ok(load_ok),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every write strobe must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (reset && pm_wren) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", pm_wr_addr, pm_wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({pm_wr_addr, pm_wr_data} !== exp_w) begin
                    errors++;
                    $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                             pm_wr_addr, pm_wr_data, exp_w[15:8], exp_w[7:0]);
                end
            end
        end
        if (reset && load_ok)  ok_cnt++;
        if (reset && load_err) err_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at posedge+1 after the transfer edge; waited = cycles stalled by in_ready=0.
    task automatic send_byte(input logic [7:0] b, output int waited);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        waited = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = in_ready;
            if (!in_ready) waited++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake: byte %h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] addr, input int unsigned n,
                              input logic [7:0] delta, input bit with_csum);
        logic [7:0] sum;
        logic [7:0] base;
        int w;
        sum = len;
        base = 8'h00;
        send_byte(SYNC, w);
        send_byte(len, w);
        if (ADDR_EN) begin
            base = addr;
            sum = sum + addr;
            send_byte(addr, w);
        end
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back({base + 8'(i), dbuf[i]});
            send_byte(dbuf[i], w);
            sum = sum + dbuf[i];
            checks++;
            if (w != 0 || pm_wren !== 1'b1 || pm_wr_data !== dbuf[i]) begin
                errors++;
                $display("FAIL write_latency: byte %0d got stall=%0d wren=%b data=%h, required stall=0 wren=1 data=%h",
                         i, w, pm_wren, pm_wr_data, dbuf[i]);
            end
        end
        if (with_csum) send_byte(8'h00 - sum + delta, w);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, pm_wren, cpu_hold, busy, load_ok, load_err, pm_wr_addr, pm_wr_data} !== {6'b101000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b wren=%b hold=%b busy=%b ok=%b err=%b addr=%h data=%h, required 1 0 1 0 0 0 00 00",
                     in_ready, pm_wren, cpu_hold, busy, load_ok, load_err, pm_wr_addr, pm_wr_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_load();
        int o0;
        int early;
        o0 = ok_cnt;
        early = 0;
        dbuf[0] = 8'h10;
        dbuf[1] = 8'h20;
        send_frame(8'h02, 8'h00, 2, 8'h00, 1'b1);
        checks++;
        if ({in_ready, cpu_hold, busy, load_ok} !== 4'b0110) begin
            errors++;
            $display("FAIL release_entry: got rdy=%b hold=%b busy=%b ok=%b, required 0 1 1 0", in_ready, cpu_hold, busy, load_ok);
        end
        for (int unsigned k = 1; k < HOLD; k++) begin
            @(posedge clk);
            #1;
            if (in_ready || !cpu_hold || load_ok) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL release_hold: got %0d early-release cycles, required 0", early);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, cpu_hold, busy, load_ok, load_err} !== 5'b10010) begin
            errors++;
            $display("FAIL release_done: got rdy=%b hold=%b busy=%b ok=%b err=%b, required 1 0 0 1 0",
                     in_ready, cpu_hold, busy, load_ok, load_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_ok !== 1'b0 || ok_cnt != o0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL good_load_pulse: got ok=%b pulses=%0d pending=%0d, required 0 1 0", load_ok, ok_cnt - o0, exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        int e0;
        int o0;
        e0 = err_cnt;
        o0 = ok_cnt;
        dbuf[0] = 8'h10;
        dbuf[1] = 8'h20;
        send_frame(8'h02, 8'h00, 2, 8'h01, 1'b1);
        checks++;
        if ({load_err, in_ready, busy, cpu_hold, load_ok} !== 5'b10110) begin
            errors++;
            $display("FAIL bad_csum_error: got err=%b rdy=%b busy=%b hold=%b ok=%b, required 1 0 1 1 0",
                     load_err, in_ready, busy, cpu_hold, load_ok);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({load_err, busy, cpu_hold, in_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL bad_csum_idle: got err=%b busy=%b hold=%b rdy=%b, required 0 0 1 1", load_err, busy, cpu_hold, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_cnt != e0 + 1 || ok_cnt != o0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bad_csum_pulses: got err_pulses=%0d ok_pulses=%0d pending=%0d, required 1 0 0",
                     err_cnt - e0, ok_cnt - o0, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int first;
        first = 0;
        dbuf[0] = 8'h10;
        send_frame(8'h02, 8'h00, 1, 8'h00, 1'b0);
        for (int unsigned k = 1; k <= TO + 4; k++) begin
            @(posedge clk);
            #1;
            if (load_err && first == 0) first = int'(k);
        end
        checks++;
        if (first != int'(TO)) begin
            errors++;
            $display("FAIL timeout_cycle: got load_err after %0d idle cycles, required %0d", first, TO);
        end
        checks++;
        if ({busy, cpu_hold, in_ready, exp_q.size() == 0} !== 4'b0111) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b hold=%b rdy=%b pending=%0d, required 0 1 1 0", busy, cpu_hold, in_ready, exp_q.size());
        end
    endtask

    task automatic test_release_backpressure();
        int w;
        int o0;
        o0 = ok_cnt;
        for (int i = 0; i < 3; i++) dbuf[i] = 8'($urandom);
        send_frame(8'h03, 8'h40, 3, 8'h00, 1'b1);
        send_byte(8'h55, w);
        checks++;
        if (w != int'(HOLD)) begin
            errors++;
            $display("FAIL release_stall: got %0d stalled cycles, required %0d", w, HOLD);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, in_ready, cpu_hold} !== 3'b010 || ok_cnt != o0 + 1) begin
            errors++;
            $display("FAIL idle_drop: got busy=%b rdy=%b hold=%b ok_pulses=%0d, required 0 1 0 1", busy, in_ready, cpu_hold, ok_cnt - o0);
        end
    endtask

    task automatic test_wrap();
        int o0;
        int n;
        o0 = ok_cnt;
        if (ADDR_EN) begin
            dbuf[0] = 8'h11;
            dbuf[1] = 8'h22;
            dbuf[2] = 8'h33;
            send_frame(8'h03, 8'hFE, 3, 8'h00, 1'b1);
            n = 3;
        end else begin
            for (int i = 0; i < 256; i++) dbuf[i] = 8'($urandom);
            send_frame(8'h00, 8'h00, 256, 8'h00, 1'b1);
            n = 256;
        end
        repeat (HOLD + 2) @(posedge clk);
        #1;
        checks++;
        if (ok_cnt != o0 + 1 || exp_q.size() != 0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load: %0d bytes got ok_pulses=%0d pending=%0d hold=%b, required 1 0 0", n, ok_cnt - o0, exp_q.size(), cpu_hold);
        end
    endtask

    task automatic test_reset_mid_data();
        dbuf[0] = 8'h3C;
        dbuf[1] = 8'hC3;
        send_frame(8'h06, 8'h00, 2, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, pm_wren, cpu_hold, busy, load_ok, load_err, pm_wr_addr, pm_wr_data} !== {6'b101000, 16'h0000}
            || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_data: got rdy=%b wren=%b hold=%b busy=%b ok=%b err=%b addr=%h data=%h pending=%0d, required 1 0 1 0 0 0 00 00 0",
                     in_ready, pm_wren, cpu_hold, busy, load_ok, load_err, pm_wr_addr, pm_wr_data, exp_q.size());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({busy, pm_wren, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL after_reset_idle: got busy=%b wren=%b rdy=%b, required 0 0 1", busy, pm_wren, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_timeout();
        test_release_backpressure();
        test_wrap();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
